// File: rtl/prog_time_ticker.sv
// Programmable cycle ticker: one-cycle done pulse every final_reg+1 enabled cycles,
// periodic or one-shot; all outputs registered, no backpressure (enable only qualifies counting).
module prog_time_ticker #(
   parameter int WIDTH         = 16,
   parameter int DEFAULT_FINAL = 10,
   parameter int TICK_CNT_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [WIDTH-1:0]      final_value,
   input  logic                  mode,
   input  logic                  clear,
   output logic                  done,
   output logic [WIDTH-1:0]      count,
   output logic                  running,
   output logic [TICK_CNT_W-1:0] tick_count
);

   typedef enum logic {ARMED = 1'b0, EXPIRED = 1'b1} state_t;

   localparam logic [WIDTH-1:0] DEF_FINAL = WIDTH'(DEFAULT_FINAL);

   state_t           state;
   logic [WIDTH-1:0] final_reg;
   logic             mode_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         final_reg  <= DEF_FINAL;
         mode_reg   <= 1'b0;
         count      <= '0;
         done       <= 1'b0;
         tick_count <= '0;
         state      <= ARMED;
         running    <= 1'b1;
      end else if (load) begin
         final_reg <= final_value;
         mode_reg  <= mode;
         count     <= '0;
         done      <= 1'b0;
         state     <= ARMED;
         running   <= 1'b1;
      end else if (clear) begin
         count      <= '0;
         done       <= 1'b0;
         tick_count <= '0;
         state      <= ARMED;
         running    <= 1'b1;
      end else begin
         case (state)
            ARMED: begin
               done <= 1'b0;
               if (enable) begin
                  if (count == final_reg) begin
                     // terminal count: wrap, pulse, and park if one-shot
                     count      <= '0;
                     done       <= 1'b1;
                     tick_count <= tick_count + TICK_CNT_W'(1);
                     if (mode_reg) begin
                        state   <= EXPIRED;
                        running <= 1'b0;
                     end
                  end else begin
                     count <= count + WIDTH'(1);
                  end
               end
            end
            default: begin
               count   <= '0;
               done    <= 1'b0;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_time_ticker.sv
// Self-checking bench for prog_time_ticker: directed scenarios plus random stimulus
// compared every cycle against an arithmetic reference model.
module tb_prog_time_ticker;

   localparam int W  = 8;
   localparam int DF = 10;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0, enable = 1'b0, load = 1'b0, mode = 1'b0, clear = 1'b0;
   logic [W-1:0]  final_value = '0;
   logic          done, running;
   logic [W-1:0]  count;
   logic [TW-1:0] tick_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_count = 0, m_final = DF, m_tick = 0;
   bit m_mode = 0, m_expired = 0, m_done = 0;

   prog_time_ticker #(.WIDTH(W), .DEFAULT_FINAL(DF), .TICK_CNT_W(TW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .final_value(final_value), .mode(mode), .clear(clear),
      .done(done), .count(count), .running(running), .tick_count(tick_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock: apply inputs, advance the model by the spec's rules, compare
   task automatic step(input bit r, input bit en, input bit ld, input int fv, input bit md, input bit cl);
      reset = r; enable = en; load = ld; final_value = W'(fv); mode = md; clear = cl;
      @(posedge clk);
      if (r) begin
         m_final = DF; m_mode = 0; m_count = 0; m_done = 0; m_tick = 0; m_expired = 0;
      end else if (ld) begin
         m_final = fv; m_mode = md; m_count = 0; m_done = 0; m_expired = 0;
      end else if (cl) begin
         m_count = 0; m_done = 0; m_tick = 0; m_expired = 0;
      end else if (m_expired || !en) begin
         m_done = 0;
      end else if (m_count == m_final) begin
         m_count = 0; m_done = 1; m_tick = (m_tick + 1) % (1 << TW);
         if (m_mode) m_expired = 1;
      end else begin
         m_count = m_count + 1; m_done = 0;
      end
      #1;
      check("done", done, m_done);
      check("count", count, m_count);
      check("running", running, !m_expired);
      check("tick_count", tick_count, m_tick);
   endtask

   task automatic idle(input bit en);
      step(0, en, 0, 0, 0, 0);
   endtask

   // enabled steps until done appears; n = steps taken, 0 if the bound expired
   task automatic until_done(input int max, output int n);
      n = 0;
      for (int i = 1; i <= max; i++) begin
         idle(1);
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n, first, second, dones;

      // reset state
      step(1, 0, 0, 0, 0, 0);
      check("rst_count", count, 0);
      check("rst_done", done, 0);
      check("rst_running", running, 1);
      check("rst_tick", tick_count, 0);

      // enable held: done every 11 cycles, tick_count 3 after 33
      first = 0; dones = 0;
      for (int i = 1; i <= 33; i++) begin
         idle(1);
         if (i == 10) check("count_at_final", count, 10);
         if (done) begin
            dones++;
            if (first == 0) first = i;
         end
      end
      check("first_done_cycle", first, 11);
      check("dones_in_33", dones, 3);
      check("tick_after_33", tick_count, 3);

      // enable toggling doubles the period
      step(1, 0, 0, 0, 0, 0);
      first = 0; second = 0;
      for (int i = 1; i <= 50; i++) begin
         idle(i % 2 == 1);
         if (done) begin
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
      end
      check("toggle_period", second - first, 22);

      // one-shot final 3
      step(0, 1, 1, 3, 1, 0);
      until_done(20, n);
      check("oneshot_latency", n, 4);
      idle(1);
      check("oneshot_running", running, 0);
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         idle(1);
         if (done) dones++;
      end
      check("oneshot_no_more", dones, 0);
      step(0, 1, 0, 0, 0, 1);
      check("clear_running", running, 1);
      until_done(20, n);
      check("rearm_latency", n, 4);

      // final 0 periodic: done every cycle, tick wraps after 256
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 0, 0, 0);
      dones = 0;
      for (int i = 1; i <= 256; i++) begin
         idle(1);
         if (done && count == 0) dones++;
         if (i == 255) check("tick_255", tick_count, 255);
      end
      check("final0_dones", dones, 256);
      check("tick_wrap", tick_count, 0);

      // load coincident with terminal count
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) idle(1);
      check("pre_load_count", count, 10);
      step(0, 1, 1, 5, 0, 0);
      check("coinc_done", done, 0);
      check("coinc_tick", tick_count, 0);
      until_done(20, n);
      check("after_load_period", n, 6);

      // reset mid-period restores default final
      step(0, 1, 1, 20, 0, 0);
      for (int i = 0; i < 7; i++) idle(1);
      check("mid_count", count, 7);
      step(1, 1, 0, 0, 0, 0);
      check("midrst_count", count, 0);
      check("midrst_running", running, 1);
      check("midrst_tick", tick_count, 0);
      until_done(30, n);
      check("midrst_period", n, 11);

      // all-ones final wraps cleanly
      step(0, 1, 1, (1 << W) - 1, 0, 0);
      for (int i = 0; i < 255; i++) idle(1);
      check("max_count", count, (1 << W) - 1);
      idle(1);
      check("max_wrap_done", done, 1);
      check("max_wrap_count", count, 0);

      // random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         bit r, ld, cl, en, md;
         int fv, sel;
         r   = ($urandom_range(0, 199) == 0);
         ld  = ($urandom_range(0, 29) == 0);
         cl  = ($urandom_range(0, 39) == 0);
         en  = ($urandom_range(0, 3) != 0);
         md  = ($urandom_range(0, 2) == 0);
         sel = $urandom_range(0, 9);
         fv  = (sel == 0) ? 0 : (sel == 1) ? (1 << W) - 1 : $urandom_range(1, 12);
         step(r, en, ld, fv, md, cl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_time_ticker.md
Name: prog_time_ticker

Overview:
Runtime-programmable successor of the fixed-period time ticker used by the debouncer.
- Counts enabled clock cycles up to a loadable terminal value and emits a one-cycle done pulse.
- Supports periodic and one-shot modes, restart (clear) and a wrapping count of completed periods.
- Provides the sample tick for debouncers and other timed logic, with different periods selectable without re-synthesis.

Parameters:
WIDTH, 16, bit width of the cycle counter and of final_value
DEFAULT_FINAL, 10, terminal value loaded at reset; must fit in WIDTH bits
TICK_CNT_W, 8, bit width of the completed-period counter tick_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count qualifier; counter advances only when high
load  input  1  one-cycle strobe: capture final_value and mode, restart period
final_value  input  WIDTH  new terminal value, sampled only when load=1
mode  input  1  sampled only when load=1; 0 = periodic, 1 = one-shot
clear  input  1  one-cycle strobe: restart period, keep final/mode, zero tick_count
done  output  1  one-cycle pulse on the cycle the terminal count is reached
count  output  WIDTH  current cycle count, 0..final_reg
running  output  1  1 in ARMED state, 0 in EXPIRED state
tick_count  output  TICK_CNT_W  number of done pulses since reset/clear, wraps

Behaviour:
- Reset values (reset=1 at a clock edge):
  - final_reg=DEFAULT_FINAL, mode_reg=0 (periodic), count=0, done=0, tick_count=0.
  - State=ARMED, running=1.
- Registered outputs: all outputs come from registers; there is no combinational path from inputs to outputs.
- Priority per edge: reset > load > clear > counting.
- State ARMED:
  - enable=1 and count<final_reg: count<=count+1, done<=0.
  - enable=1 and count==final_reg: count<=0, done<=1, tick_count<=tick_count+1 (mod 2^TICK_CNT_W).
    - If mode_reg=1, next state is EXPIRED.
  - enable=0: count holds, done<=0.
- Period: done fires once every final_reg+1 enabled cycles, on the edge after the one where count==final_reg with enable=1.
  - With enable held high, the first done pulse after reset is high during cycle DEFAULT_FINAL+1 after reset release.
- State EXPIRED (one-shot finished):
  - count held at 0, done<=0, running=0, enable ignored.
  - Leaves only via load, clear or reset, each returning to ARMED.
- load=1:
  - final_reg<=final_value, mode_reg<=mode, count<=0, done<=0, state<=ARMED.
  - tick_count is unchanged.
  - enable is ignored that cycle; no count or done occurs on the load edge.
- clear=1 (load=0): count<=0, done<=0, tick_count<=0, state<=ARMED; final_reg and mode_reg are unchanged.
- final_reg=0: done is high on every enabled cycle in periodic mode, and count stays 0.
- final_reg=2^WIDTH-1: count reaches all-ones, then wraps to 0 with done. No overflow beyond that.
- A terminal count coincident with load or clear: load/clear wins, no done is issued, and tick_count is not incremented.
- Reset mid-period or in EXPIRED: everything returns to reset values on that edge, including final_reg=DEFAULT_FINAL.
- tick_count wraps from 2^TICK_CNT_W-1 to 0 silently; there is no saturation or flag.

Test Plan:
- Reset then enable=1 held, defaults (DEFAULT_FINAL=10) -> done pulses for exactly 1 cycle every 11 cycles; count sequence 0..10; tick_count=3 after 33 enabled cycles.
- Toggle enable 1/0 every cycle with final 10 -> done period doubles to 22 cycles; count holds when enable=0.
- load final_value=3, mode=1, enable=1 -> single done 4 cycles after load; running drops to 0 next cycle; no further done over 50 cycles; clear -> running=1 and next done 4 cycles later.
- load final_value=0, mode=0 -> done high every enabled cycle; count stays 0; with TICK_CNT_W=8, tick_count wraps 255->0 after 256 cycles.
- Assert load (final 5) exactly on the edge where count==10 -> no done pulse, tick_count unchanged, next done 6 cycles later.
- Assert reset mid-period (count=7) after load final 20 -> count=0, running=1, tick_count=0, next done after 11 cycles (final back to 10).
